stream_demux: RTL and testbench

Parametrised, registered 1:N demultiplexer for valid/ready streams. It is the successor to the combinational 1:8 bit demux.
- Each accepted input word is steered by a select field into one per-channel holding register, or into all channels in broadcast mode.
- Back-pressure is handled per channel.
- Out-of-range selects are discarded and counted.
- Sits between a single producer and N independent consumers (e.g. per-lane FIFOs).

---
 rtl/stream_pkg.sv | 14 +
 rtl/stream_demux_slot.sv | 31 +++
 rtl/stream_demux.sv | 91 +++++++++
 tb/tb_stream_demux.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared helpers for the stream demultiplexer family.
package stream_pkg;

   // Select field width for an N-way steer; never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Saturation value of a w-bit counter (all ones).
   function automatic longint unsigned sat_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// Single-entry holding register for one output channel of the demux.
module stream_demux_slot #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          can_acc
);

   // The slot can take a word when it is empty or is being drained this cycle.
   assign can_acc = !out_valid || out_ready;

   // Load wins over drain so a drain-and-refill keeps valid high with no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux.sv
// Registered 1:N valid/ready demultiplexer with broadcast and drop counting.
// Unselected channels are left untouched by a transfer; data registers keep
// their last value after being consumed.
module stream_demux
   import stream_pkg::*;
#(
   parameter  int DW    = 8,
   parameter  int N     = 8,
   parameter  int CNT_W = 8,
   localparam int SEL_W = sel_width(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_data,
   input  logic [SEL_W-1:0]  in_sel,
   input  logic              in_bcast,
   output logic [N-1:0]      out_valid,
   input  logic [N-1:0]      out_ready,
   output logic [N*DW-1:0]   out_data,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic              drop_pulse
);

   localparam logic [CNT_W-1:0] DROP_MAX = CNT_W'(sat_max(CNT_W));

   logic [N-1:0] can_acc;
   logic [N-1:0] load;
   logic         in_range;
   logic         sel_acc;
   logic         xfer;
   logic         drop;

   // Out-of-range selects only exist when N is not a power of two.
   assign in_range = (int'(in_sel) < N);

   // Ready depends only on the select/broadcast fields and channel state, never on in_valid.
   always_comb begin
      sel_acc = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (int'(in_sel) == i) sel_acc = can_acc[i];
      end
      if (in_bcast)
         in_ready = &can_acc;
      else if (in_range)
         in_ready = sel_acc;
      else
         in_ready = 1'b1;
   end

   assign xfer = in_valid && in_ready;
   assign drop = xfer && !in_bcast && !in_range;

   // Decode the accepted word into per-channel load strobes.
   always_comb begin
      load = '0;
      for (int i = 0; i < N; i++) begin
         load[i] = xfer && (in_bcast || (int'(in_sel) == i));
      end
   end

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_slot
         stream_demux_slot #(.DW(DW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[g]),
            .load_data (in_data),
            .out_ready (out_ready[g]),
            .out_valid (out_valid[g]),
            .out_data  (out_data[g*DW +: DW]),
            .can_acc   (can_acc[g])
         );
      end
   endgenerate

   // Dropped words raise a one-cycle pulse and bump a saturating counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_pulse <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         drop_pulse <= drop;
         if (drop && (drop_cnt != DROP_MAX))
            drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: an 8-channel instance and a
// 5-channel instance with a 2-bit drop counter for the out-of-range cases.
module tb_stream_demux;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic        a_in_valid, a_in_ready, a_in_bcast, a_drop_pulse;
   logic [7:0]  a_in_data;
   logic [2:0]  a_in_sel;
   logic [7:0]  a_out_valid, a_out_ready, a_drop_cnt;
   logic [63:0] a_out_data;

   logic        b_in_valid, b_in_ready, b_in_bcast, b_drop_pulse;
   logic [7:0]  b_in_data;
   logic [2:0]  b_in_sel;
   logic [4:0]  b_out_valid, b_out_ready;
   logic [39:0] b_out_data;
   logic [1:0]  b_drop_cnt;

   stream_demux #(.DW(8), .N(8), .CNT_W(8)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_sel(a_in_sel), .in_bcast(a_in_bcast),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .drop_cnt(a_drop_cnt), .drop_pulse(a_drop_pulse)
   );

   stream_demux #(.DW(8), .N(5), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_sel(b_in_sel), .in_bcast(b_in_bcast),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .drop_cnt(b_drop_cnt), .drop_pulse(b_drop_pulse)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard for instance A: words pushed when accepted, popped when consumed.
   logic [7:0] sbq [8][$];

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) sbq[i].delete();
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (a_out_valid[i] && a_out_ready[i]) begin
               if (sbq[i].size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL sb_unexpected_ch%0d: got %0h, expected no word", i, a_out_data[i*8 +: 8]);
               end else begin
                  check($sformatf("sb_ch%0d", i), 64'(a_out_data[i*8 +: 8]), 64'(sbq[i].pop_front()));
               end
            end
         end
         if (a_in_valid && a_in_ready) begin
            for (int i = 0; i < 8; i++) begin
               if (a_in_bcast || (int'(a_in_sel) == i)) sbq[i].push_back(a_in_data);
            end
         end
      end
   end

   typedef struct {
      logic [2:0] sel;
      logic       bcast;
      logic [7:0] data;
      logic [7:0] oready;
      logic       exp_rdy;
      logic [7:0] exp_valid;
   } vec_t;

   vec_t vt [10];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_drop;
      int sb_left;

      for (int k = 0; k < 8; k++)
         vt[k] = '{sel: 3'(k), bcast: 1'b0, data: 8'(8'hA0 + k), oready: 8'hFF,
                   exp_rdy: 1'b1, exp_valid: 8'(1 << k)};
      vt[8] = '{sel: 3'd0, bcast: 1'b1, data: 8'h3C, oready: 8'hFF, exp_rdy: 1'b1, exp_valid: 8'hFF};
      vt[9] = '{sel: 3'd1, bcast: 1'b0, data: 8'hB1, oready: 8'hFF, exp_rdy: 1'b1, exp_valid: 8'h02};

      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_bcast = 1'b0; a_in_data = '0; a_in_sel = '0; a_out_ready = '1;
      b_in_valid = 1'b0; b_in_bcast = 1'b0; b_in_data = '0; b_in_sel = '0; b_out_ready = '1;
      #12;

      // Reset state and idle readiness.
      check("rst_a_valid", 64'(a_out_valid), 64'h0);
      check("rst_a_data", a_out_data, 64'h0);
      check("rst_a_dropcnt", 64'(a_drop_cnt), 64'h0);
      check("rst_b_valid", 64'(b_out_valid), 64'h0);
      check("rst_b_dropcnt", 64'(b_drop_cnt), 64'h0);
      for (int s = 0; s < 8; s++) begin
         a_in_sel = 3'(s);
         #1 check($sformatf("idle_rdy_a_sel%0d", s), 64'(a_in_ready), 64'h1);
      end
      for (int s = 0; s < 5; s++) begin
         b_in_sel = 3'(s);
         #1 check($sformatf("idle_rdy_b_sel%0d", s), 64'(b_in_ready), 64'h1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Table-driven unicast sweep plus broadcast rows, one word per cycle.
      for (int k = 0; k < 10; k++) begin
         a_in_valid  = 1'b1;
         a_in_sel    = vt[k].sel;
         a_in_bcast  = vt[k].bcast;
         a_in_data   = vt[k].data;
         a_out_ready = vt[k].oready;
         @(negedge clk);
         check($sformatf("vec%0d_in_ready", k), 64'(a_in_ready), 64'(vt[k].exp_rdy));
         tick();
         check($sformatf("vec%0d_out_valid", k), 64'(a_out_valid), 64'(vt[k].exp_valid));
         for (int i = 0; i < 8; i++) begin
            if (vt[k].exp_valid[i])
               check($sformatf("vec%0d_data_ch%0d", k, i), 64'(a_out_data[i*8 +: 8]), 64'(vt[k].data));
         end
      end
      a_in_valid = 1'b0;
      a_in_bcast = 1'b0;
      tick();

      // Back-pressure isolation on channel 3.
      a_out_ready = 8'hF7;
      a_in_valid = 1'b1; a_in_sel = 3'd3; a_in_data = 8'h11;
      tick();
      check("bp_ch3_valid", 64'(a_out_valid[3]), 64'h1);
      check("bp_ch3_data", 64'(a_out_data[31:24]), 64'h11);
      a_in_data = 8'h22;
      @(negedge clk);
      check("bp_ch3_blocked", 64'(a_in_ready), 64'h0);
      tick();
      check("bp_ch3_held", 64'(a_out_data[31:24]), 64'h11);
      a_in_sel = 3'd5; a_in_data = 8'h33;
      @(negedge clk);
      check("bp_ch5_ready", 64'(a_in_ready), 64'h1);
      tick();
      check("bp_ch5_valid", 64'(a_out_valid[5]), 64'h1);
      check("bp_ch5_data", 64'(a_out_data[47:40]), 64'h33);
      check("bp_ch3_still", 64'(a_out_data[31:24]), 64'h11);
      a_in_sel = 3'd3; a_in_data = 8'h22; a_out_ready = 8'hFF;
      @(negedge clk);
      check("bp_ch3_release_rdy", 64'(a_in_ready), 64'h1);
      tick();
      check("bp_ch3_nobubble_valid", 64'(a_out_valid[3]), 64'h1);
      check("bp_ch3_nobubble_data", 64'(a_out_data[31:24]), 64'h22);
      a_in_valid = 1'b0;
      tick();

      // Broadcast blocked by a full, stalled channel 6.
      a_out_ready = 8'hBF;
      a_in_valid = 1'b1; a_in_sel = 3'd6; a_in_data = 8'h66;
      tick();
      a_in_bcast = 1'b1; a_in_data = 8'h5A;
      @(negedge clk);
      check("bc_blocked", 64'(a_in_ready), 64'h0);
      tick();
      check("bc_ch6_held", 64'(a_out_data[55:48]), 64'h66);
      a_out_ready = 8'hFF;
      @(negedge clk);
      check("bc_release_rdy", 64'(a_in_ready), 64'h1);
      tick();
      check("bc_all_valid", 64'(a_out_valid), 64'hFF);
      check("bc_all_data", a_out_data, 64'h5A5A5A5A5A5A5A5A);
      a_in_valid = 1'b0; a_in_bcast = 1'b0;
      tick();
      tick();
      check("a_no_drops", 64'(a_drop_cnt), 64'h0);
      sb_left = 0;
      for (int i = 0; i < 8; i++) sb_left += sbq[i].size();
      check("sb_drained", 64'(sb_left), 64'h0);

      // Asynchronous reset while channel 2 holds a word.
      a_out_ready = 8'hFB;
      a_in_valid = 1'b1; a_in_sel = 3'd2; a_in_data = 8'h77;
      tick();
      a_in_valid = 1'b0;
      check("ar_ch2_loaded", 64'(a_out_valid[2]), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid_cleared", 64'(a_out_valid), 64'h0);
      check("ar_data_cleared", a_out_data, 64'h0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      a_out_ready = 8'hFF;
      a_in_valid = 1'b1; a_in_sel = 3'd2; a_in_data = 8'h99;
      @(negedge clk);
      check("ar_post_rdy", 64'(a_in_ready), 64'h1);
      tick();
      check("ar_post_valid", 64'(a_out_valid), 64'h04);
      check("ar_post_data", 64'(a_out_data[23:16]), 64'h99);
      a_in_valid = 1'b0;
      tick();

      // Out-of-range selects on the 5-channel instance, 2-bit saturating counter.
      exp_drop = 0;
      b_in_valid = 1'b1; b_in_sel = 3'd6; b_in_data = 8'hD0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("drop%0d_rdy", k), 64'(b_in_ready), 64'h1);
         tick();
         exp_drop = (exp_drop == 3) ? 3 : exp_drop + 1;
         check($sformatf("drop%0d_valid", k), 64'(b_out_valid), 64'h0);
         check($sformatf("drop%0d_pulse", k), 64'(b_drop_pulse), 64'h1);
         check($sformatf("drop%0d_cnt", k), 64'(b_drop_cnt), 64'(exp_drop));
      end
      b_in_valid = 1'b0;
      tick();
      check("drop_pulse_idle", 64'(b_drop_pulse), 64'h0);
      check("drop_cnt_hold", 64'(b_drop_cnt), 64'h3);
      b_in_valid = 1'b1; b_in_sel = 3'd4; b_in_data = 8'h44;
      @(negedge clk);
      check("b_top_rdy", 64'(b_in_ready), 64'h1);
      tick();
      check("b_top_valid", 64'(b_out_valid), 64'h10);
      check("b_top_data", 64'(b_out_data[39:32]), 64'h44);
      check("b_top_nopulse", 64'(b_drop_pulse), 64'h0);
      b_in_sel = 3'd5; b_in_data = 8'h55;
      tick();
      check("b_sel5_pulse", 64'(b_drop_pulse), 64'h1);
      check("b_sel5_valid", 64'(b_out_valid), 64'h0);
      b_in_bcast = 1'b1; b_in_sel = 3'd7; b_in_data = 8'hEE;
      @(negedge clk);
      check("b_bc_rdy", 64'(b_in_ready), 64'h1);
      tick();
      check("b_bc_valid", 64'(b_out_valid), 64'h1F);
      check("b_bc_data", 64'(b_out_data), 64'hEEEEEEEEEE);
      check("b_bc_nodrop", 64'(b_drop_pulse), 64'h0);
      b_in_valid = 1'b0; b_in_bcast = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
